mux_stream_n: RTL and testbench
===============================

# mux_stream_n

Parametrised successor to the combinational 4-way 16-bit mux. It selects one of N WIDTH-bit input streams, each with a valid/ready handshake. Selection is either by an explicit `sel` input or by round-robin arbitration. The winning word is presented through a single registered output stage with full back-pressure. It sits between multiple producers (e.g. CPU data path, memory-mapped peripherals, screen/keyboard bridges) and one consumer.

## Interface
Parameters:
- `WIDTH`, 16, data width per channel.
- `N`, 4, number of input channels; legal range 2..16, not necessarily a power of two.
- `SELW`, `$clog2(N)`, derived; width of `sel` and `out_chan`.

Ports:
- `clk`  in  1  system clock; all state is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; combinational.
- `mode`  in  1  0 = explicit select, 1 = round-robin.
- `sel`  in  SELW  channel index used when `mode`=0.
- `out_data`  out  WIDTH  registered output word.
- `out_chan`  out  SELW  registered index of the channel that produced `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- Output stage: one register holding `out_data`, `out_chan` and `out_valid`.
- `load_en` = !`out_valid` || `out_ready`.
- Grant selection (combinational):
  - `mode`=0: grant = `sel` when `sel` < N and `in_valid[sel]`=1; otherwise no grant. Other valid channels are ignored.
  - `mode`=1: grant = first i with `in_valid[i]`=1, searching cyclically from `rr_ptr`+1 mod N through `rr_ptr`; no grant if all `in_valid` are 0.
- `in_ready[i]` = `load_en` && grant exists && grant == i. At most one `in_ready` bit is high per cycle. `in_ready` may depend on `in_valid`.
- Transfer on channel i occurs when `in_valid[i]` && `in_ready[i]`. On a transfer the register loads `in_data[i]`, `out_chan`=i and `out_valid`=1.
- When `load_en`=1 and there is no grant, `out_valid` clears to 0. `out_data` and `out_chan` hold their previous values.
- When `load_en`=0 the register holds. `out_data`, `out_chan` and `out_valid` stay stable while `out_valid` && !`out_ready`.
- `rr_ptr` (SELW bits) is updated to the granted index only on a transfer in `mode`=1. It is not updated in `mode`=0.
- `mode` or `sel` changes take effect on the next cycle's arbitration. The output register contents are unaffected.
- Reset: `out_valid`=0, `out_data`=0, `out_chan`=0, `rr_ptr`=N-1, so channel 0 has first priority after reset. `in_ready` is all-zero while `reset_n`=0.
- Reset asserted mid-transfer discards the held word.

## Timing
- Latency: 1 cycle from an input transfer to the word appearing on `out_data` with `out_valid`=1.
- Throughput: one word per cycle while `out_ready`=1.
- No combinational path from `in_data` to `out_data`.
- Combinational path from `out_ready`, `in_valid`, `mode`, `sel` and `rr_ptr` to `in_ready`.
- Simultaneous pop and push in one cycle (`out_valid`=1, `out_ready`=1, input transfer): the new word replaces the old one in that same edge; no bubble.
- Round-robin fairness: with all N channels continuously valid and `out_ready`=1, each channel is granted exactly once in every N consecutive cycles.

## Structure
- Shared package `mux_stream_pkg`: `MODE_SEL`=1'b0, `MODE_RR`=1'b1.
- One sub-module, `rr_arbiter`:
  - parameter N;
  - inputs `req`[N], `ptr`[SELW];
  - outputs `gnt_valid`, `gnt_idx`[SELW];
  - purely combinational.
- The top level holds the output register and `rr_ptr`.

## Test plan
- Reset check: hold `reset_n`=0 → `out_valid`=0, `out_data`=0, `in_ready`=0. Release, then drive `in_valid`=4'b1111, `mode`=1 → first grant is channel 0.
- Explicit select: `mode`=0, `sel`=2, `in_data[2]`=16'hBEEF, `in_valid`=4'b0101 → `in_ready`=4'b0100. Next cycle `out_data`=16'hBEEF, `out_chan`=2. With `sel`=1 (not valid) → no grant, and `out_valid` drops to 0 after the consumer takes the held word.
- Round-robin fairness: `mode`=1, all valid, `out_ready`=1 for 8 cycles → `out_chan` sequence 0,1,2,3,0,1,2,3, one word per cycle.
- Back-pressure: `out_valid`=1 with `out_ready`=0 for 3 cycles → `in_ready`=0 and outputs unchanged for all 3 cycles. Raising `out_ready` gives a pop and a new push in the same cycle.
- Sparse requests: `mode`=1, `rr_ptr`=1, `in_valid`=4'b1001 → grant 3, then 0, then 3 (channels 1 and 2 skipped).
- Non-power-of-two: N=3, `mode`=0, `sel`=3 → no grant ever. Reset asserted while `out_valid`=1 → `out_valid`=0 asynchronously.

Source files
------------

// File: rtl/mux_stream_pkg.sv
// Shared definitions for the N-way streaming mux: arbitration mode encodings.
package mux_stream_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/mux_stream_n_rr_arbiter.sv
// Combinational round-robin arbiter: first requester found cyclically after ptr.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!gnt_valid && req[i] && (i == (int'(ptr) + k) % N)) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel valid/ready stream mux (explicit or round-robin select) with a
// single registered, fully back-pressured output stage.
module mux_stream_n
    import mux_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             rr_gnt_valid;
    logic [SELW-1:0]  rr_gnt_idx;
    logic             sel_hit;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load_en;
    logic             push;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    // A sel value at or above N matches no channel, so it never grants.
    always_comb begin
        sel_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                sel_hit = in_valid[i];
            end
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            gnt_valid = rr_gnt_valid;
            gnt_idx   = rr_gnt_idx;
        end else begin
            gnt_valid = sel_hit;
            gnt_idx   = sel;
        end
    end

    always_comb begin
        load_en  = !out_valid_q || out_ready;
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = reset_n && load_en && gnt_valid && (gnt_idx == SELW'(i));
            if (gnt_idx == SELW'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
        push = |(in_valid & in_ready);
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_valid_d = push;
        end
        if (push) begin
            out_data_d = gnt_data;
            out_chan_d = gnt_idx;
            if (mode == MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_n.sv
// Directed self-checking bench for mux_stream_n (N=4 main instance, N=3 instance).
module tb_mux_stream_n;

    logic        clk;
    logic        reset_n;

    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [47:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [15:0] out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;

    int errors = 0;
    int checks = 0;

    mux_stream_n #(.WIDTH(16), .N(4)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_stream_n #(.WIDTH(16), .N(3)) u_dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic after_rise();
        @(posedge clk);
        #1;
    endtask

    task automatic at_fall();
        @(negedge clk);
    endtask

    localparam logic [63:0] BASE_DATA = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    logic [15:0] ch_data [4] = '{16'hA000, 16'hB001, 16'hC002, 16'hD003};

    initial begin
        reset_n    = 1'b0;
        in_data    = BASE_DATA;
        in_valid   = 4'b1111;
        mode       = 1'b1;
        sel        = 2'd0;
        out_ready  = 1'b1;
        in_data3   = {16'h3333, 16'h2222, 16'h1111};
        in_valid3  = 3'b111;
        mode3      = 1'b0;
        sel3       = 2'd3;
        out_ready3 = 1'b1;

        // Reset held: outputs cleared, no ready even with every channel valid.
        after_rise();
        after_rise();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_in_ready3", 32'(in_ready3), 32'h0);

        // Release: round-robin first grant is channel 0, then fairness over 8 cycles.
        at_fall();
        reset_n = 1'b1;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            after_rise();
            check($sformatf("rr_chan_%0d", k), 32'(out_chan), 32'(k % 4));
            check($sformatf("rr_data_%0d", k), 32'(out_data), 32'(ch_data[k % 4]));
            check($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
        end

        // Explicit select of channel 2 with channels 0 and 2 valid.
        at_fall();
        mode            = 1'b0;
        sel             = 2'd2;
        in_valid        = 4'b0101;
        in_data[47:32]  = 16'hBEEF;
        #1;
        check("sel2_in_ready", 32'(in_ready), 32'b0100);
        after_rise();
        check("sel2_out_data", 32'(out_data), 32'hBEEF);
        check("sel2_out_chan", 32'(out_chan), 32'd2);
        check("sel2_out_valid", 32'(out_valid), 32'd1);

        // Select an idle channel while the consumer stalls, then drains.
        at_fall();
        sel       = 2'd1;
        out_ready = 1'b0;
        #1;
        check("sel1_stall_ready", 32'(in_ready), 32'h0);
        after_rise();
        check("sel1_hold_valid", 32'(out_valid), 32'd1);
        check("sel1_hold_data", 32'(out_data), 32'hBEEF);
        at_fall();
        out_ready = 1'b1;
        #1;
        check("sel1_no_grant", 32'(in_ready), 32'h0);
        after_rise();
        check("sel1_drained_valid", 32'(out_valid), 32'd0);
        check("sel1_keep_data", 32'(out_data), 32'hBEEF);
        check("sel1_keep_chan", 32'(out_chan), 32'd2);

        // Back-pressure: rr_ptr is still 3, so channel 0 loads, then stalls 3 cycles.
        at_fall();
        in_data   = BASE_DATA;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        check("bp_load_ready", 32'(in_ready), 32'b0001);
        after_rise();
        check("bp_loaded_chan", 32'(out_chan), 32'd0);
        for (int k = 0; k < 3; k++) begin
            after_rise();
            check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
            check($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_data_%0d", k), 32'(out_data), 32'hA000);
            check($sformatf("bp_chan_%0d", k), 32'(out_chan), 32'd0);
        end
        at_fall();
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0010);
        after_rise();
        check("bp_popush_chan", 32'(out_chan), 32'd1);
        check("bp_popush_data", 32'(out_data), 32'hB001);
        check("bp_popush_valid", 32'(out_valid), 32'd1);

        // Sparse requests from rr_ptr=1: grants 3, 0, 3.
        at_fall();
        in_valid = 4'b1001;
        #1;
        check("sparse_ready", 32'(in_ready), 32'b1000);
        after_rise();
        check("sparse_chan_a", 32'(out_chan), 32'd3);
        after_rise();
        check("sparse_chan_b", 32'(out_chan), 32'd0);
        after_rise();
        check("sparse_chan_c", 32'(out_chan), 32'd3);
        check("sparse_data_c", 32'(out_data), 32'hD003);

        // N=3 instance: sel=3 never grants, sel=2 does.
        check("n3_sel3_ready", 32'(in_ready3), 32'h0);
        check("n3_sel3_valid", 32'(out_valid3), 32'd0);
        at_fall();
        sel3 = 2'd2;
        #1;
        check("n3_sel2_ready", 32'(in_ready3), 32'b100);
        after_rise();
        check("n3_sel2_data", 32'(out_data3), 32'h3333);
        check("n3_sel2_chan", 32'(out_chan3), 32'd2);

        // Reset mid-transfer clears the held word without a clock edge.
        at_fall();
        out_ready  = 1'b0;
        out_ready3 = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'h0);
        check("async_rst_valid3", 32'(out_valid3), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'h0);
        at_fall();
        reset_n = 1'b1;
        after_rise();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
